// File: rtl/stack_alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// stack_alu_sequencer_if
// Bundles the three streams around the RPN sequencer:
//   token stream  : tok_valid/tok_ready, tok_kind, tok_value (host -> seq)
//   ALU command   : alu_opcode, alu_data (seq -> ALU), alu_result,
//                   alu_overflow (ALU -> seq)
//   result stream : res_valid/res_ready, res_data, res_overflow, res_error
//   status        : depth (sequencer's model of ALU stack occupancy)
// Modports: slave = sequencer view, master = host/ALU environment view.
// ---------------------------------------------------------------------------
interface stack_alu_sequencer_if #(
    parameter int N         = 8,
    parameter int MAX_DEPTH = 15
);
    localparam int DW = $clog2(MAX_DEPTH + 1);

    logic           tok_valid;
    logic           tok_ready;
    logic [1:0]     tok_kind;
    logic [N-1:0]   tok_value;

    logic [2:0]     alu_opcode;
    logic [N-1:0]   alu_data;
    logic [N-1:0]   alu_result;
    logic           alu_overflow;

    logic           res_valid;
    logic           res_ready;
    logic [N-1:0]   res_data;
    logic           res_overflow;
    logic           res_error;
    logic [DW-1:0]  depth;

    modport slave (
        input  tok_valid, tok_kind, tok_value, alu_result, alu_overflow, res_ready,
        output tok_ready, alu_opcode, alu_data, res_valid, res_data,
               res_overflow, res_error, depth
    );

    modport master (
        output tok_valid, tok_kind, tok_value, alu_result, alu_overflow, res_ready,
        input  tok_ready, alu_opcode, alu_data, res_valid, res_data,
               res_overflow, res_error, depth
    );
endinterface

// File: rtl/stack_alu_sequencer.sv
// ---------------------------------------------------------------------------
// stack_alu_sequencer
// Postfix (RPN) expression sequencer driving a stack-based ALU. Accepts
// operand/operator/end tokens, issues push/op/pop opcodes one per cycle,
// and reports one result per expression with sticky overflow and error.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset (ALU is reset from ~reset)
//   bus   - stack_alu_sequencer_if.slave (token, ALU, result, depth)
// ---------------------------------------------------------------------------
module stack_alu_sequencer #(
    parameter int N         = 8,
    parameter int MAX_DEPTH = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    stack_alu_sequencer_if.slave   bus
);
    localparam int DW = $clog2(MAX_DEPTH + 1);

    localparam logic [2:0] OPC_NOP  = 3'b000;
    localparam logic [2:0] OPC_ADD  = 3'b100;
    localparam logic [2:0] OPC_MUL  = 3'b101;
    localparam logic [2:0] OPC_PUSH = 3'b110;
    localparam logic [2:0] OPC_POP  = 3'b111;

    localparam logic [DW-1:0] DEPTH_MAX  = DW'(MAX_DEPTH);
    localparam logic [DW-1:0] DEPTH_ZERO = '0;
    localparam logic [DW-1:0] DEPTH_ONE  = DW'(1);
    localparam logic [DW-1:0] DEPTH_TWO  = DW'(2);

    typedef enum logic [3:0] {
        S_ACCEPT, S_PUSH, S_OP, S_POP1, S_POP2, S_RPUSH,
        S_FPOP, S_FCAP, S_ERR, S_DRAIN, S_DONE
    } state_t;

    state_t          r_state;
    logic [2:0]      r_opcode;
    logic [N-1:0]    r_alu_data;
    logic [N-1:0]    r_temp;
    logic            r_sticky;
    logic            r_err;
    logic [DW-1:0]   r_depth;
    logic            r_res_valid;
    logic [N-1:0]    r_res_data;
    logic            r_res_overflow;
    logic            r_res_error;

    logic            w_tok_ready;
    logic            w_tok_fire;

    assign w_tok_ready = (r_state == S_ACCEPT);
    assign w_tok_fire  = bus.tok_valid & w_tok_ready;

    assign bus.tok_ready    = w_tok_ready;
    assign bus.alu_opcode   = r_opcode;
    assign bus.alu_data     = r_alu_data;
    assign bus.res_valid    = r_res_valid;
    assign bus.res_data     = r_res_data;
    assign bus.res_overflow = r_res_overflow;
    assign bus.res_error    = r_res_error;
    assign bus.depth        = r_depth;

    // The opcode register always holds the opcode of the state being
    // entered, so every transition loads r_opcode alongside r_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_ACCEPT;
            r_opcode       <= OPC_NOP;
            r_alu_data     <= '0;
            r_temp         <= '0;
            r_sticky       <= 1'b0;
            r_err          <= 1'b0;
            r_depth        <= '0;
            r_res_valid    <= 1'b0;
            r_res_data     <= '0;
            r_res_overflow <= 1'b0;
            r_res_error    <= 1'b0;
        end else begin
            case (r_state)
                S_ACCEPT: begin
                    if (w_tok_fire) begin
                        case (bus.tok_kind)
                            2'b00: begin
                                if (r_depth == DEPTH_MAX) begin
                                    r_state  <= S_ERR;
                                    r_opcode <= OPC_NOP;
                                end else begin
                                    r_state    <= S_PUSH;
                                    r_opcode   <= OPC_PUSH;
                                    r_alu_data <= bus.tok_value;
                                end
                            end
                            2'b01, 2'b10: begin
                                if (r_depth < DEPTH_TWO) begin
                                    r_state  <= S_ERR;
                                    r_opcode <= OPC_NOP;
                                end else begin
                                    r_state  <= S_OP;
                                    r_opcode <= (bus.tok_kind == 2'b01) ? OPC_ADD : OPC_MUL;
                                end
                            end
                            default: begin
                                if (r_depth == DEPTH_ONE) begin
                                    r_state  <= S_FPOP;
                                    r_opcode <= OPC_POP;
                                end else begin
                                    r_state  <= S_ERR;
                                    r_opcode <= OPC_NOP;
                                end
                            end
                        endcase
                    end
                end
                S_PUSH: begin
                    r_depth  <= r_depth + DEPTH_ONE;
                    r_state  <= S_ACCEPT;
                    r_opcode <= OPC_NOP;
                end
                S_OP: begin
                    r_state  <= S_POP1;
                    r_opcode <= OPC_POP;
                end
                S_POP1: begin
                    // Operation result is on alu_result during this cycle.
                    r_temp <= bus.alu_result;
                    if (bus.alu_overflow == 1'b1) begin
                        r_sticky <= 1'b1;
                    end
                    r_state  <= S_POP2;
                    r_opcode <= OPC_POP;
                end
                S_POP2: begin
                    r_depth    <= r_depth - DEPTH_TWO;
                    r_state    <= S_RPUSH;
                    r_opcode   <= OPC_PUSH;
                    r_alu_data <= r_temp;
                end
                S_RPUSH: begin
                    r_depth  <= r_depth + DEPTH_ONE;
                    r_state  <= S_ACCEPT;
                    r_opcode <= OPC_NOP;
                end
                S_FPOP: begin
                    r_depth  <= r_depth - DEPTH_ONE;
                    r_state  <= S_FCAP;
                    r_opcode <= OPC_NOP;
                end
                S_FCAP: begin
                    r_res_data     <= bus.alu_result;
                    r_res_overflow <= r_sticky;
                    r_res_error    <= 1'b0;
                    r_res_valid    <= 1'b1;
                    r_state        <= S_DONE;
                    r_opcode       <= OPC_NOP;
                end
                S_ERR: begin
                    r_err    <= 1'b1;
                    r_state  <= S_DRAIN;
                    r_opcode <= (r_depth != DEPTH_ZERO) ? OPC_POP : OPC_NOP;
                end
                S_DRAIN: begin
                    if (r_depth != DEPTH_ZERO) begin
                        // Pop issued this cycle; next cycle pops only if more remain.
                        r_depth  <= r_depth - DEPTH_ONE;
                        r_opcode <= (r_depth != DEPTH_ONE) ? OPC_POP : OPC_NOP;
                    end else begin
                        r_res_data     <= '0;
                        r_res_overflow <= r_sticky;
                        r_res_error    <= r_err;
                        r_res_valid    <= 1'b1;
                        r_state        <= S_DONE;
                        r_opcode       <= OPC_NOP;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_sticky    <= 1'b0;
                        r_err       <= 1'b0;
                        r_state     <= S_ACCEPT;
                        r_opcode    <= OPC_NOP;
                    end
                end
                default: begin
                    r_state  <= S_ACCEPT;
                    r_opcode <= OPC_NOP;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stack_alu_sequencer.sv
module tb_stack_alu_sequencer;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    stack_alu_sequencer_if #(.N(8), .MAX_DEPTH(15)) bus ();

    stack_alu_sequencer #(.N(8), .MAX_DEPTH(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- behavioural stack ALU (reset from ~reset) -----------
    logic [7:0] alu_stk [16];
    int         alu_sp;
    logic [7:0] alu_out;
    logic       alu_ov;

    always @(posedge clk or negedge reset) begin
        logic [7:0]  a, b, s;
        logic [15:0] p;
        if (!reset) begin
            alu_sp  <= 0;
            alu_out <= 8'h00;
            alu_ov  <= 1'b0;
        end else begin
            a = (alu_sp >= 1) ? alu_stk[alu_sp-1] : 8'h00;
            b = (alu_sp >= 2) ? alu_stk[alu_sp-2] : 8'h00;
            case (bus.alu_opcode)
                3'b110: begin
                    if (alu_sp < 16) alu_stk[alu_sp] <= bus.alu_data;
                    alu_sp <= alu_sp + 1;
                end
                3'b111: begin
                    alu_out <= a;
                    alu_sp  <= alu_sp - 1;
                end
                3'b100: begin
                    s = a + b;
                    alu_out <= s;
                    alu_ov  <= (a[7] == b[7]) && (s[7] != a[7]);
                end
                3'b101: begin
                    p = 16'($signed(a) * $signed(b));
                    alu_out <= p[7:0];
                    alu_ov  <= (p != {{8{p[7]}}, p[7:0]});
                end
                default: ;
            endcase
        end
    end
    assign bus.alu_result   = alu_out;
    assign bus.alu_overflow = alu_ov;

    // ---------------- scoreboard / bookkeeping ---------------------------
    typedef struct packed {
        logic [7:0] d;
        logic       ov;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] op_log[$];
    int         peak_depth;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each delivered result against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && bus.res_valid && bus.res_ready) begin
                $display("result: data=%0h ovf=%0b err=%0b depth=%0d",
                         bus.res_data, bus.res_overflow, bus.res_error, bus.depth);
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'(bus.res_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("res_data", 32'(bus.res_data), 32'(e.d));
                    check("res_overflow", 32'(bus.res_overflow), 32'(e.ov));
                    check("res_error", 32'(bus.res_error), 32'(e.err));
                    check("depth_at_result", 32'(bus.depth), 32'd0);
                end
            end
        end
    end

    // Opcode trace and peak occupancy.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && bus.alu_opcode != 3'b000) op_log.push_back(bus.alu_opcode);
            if (int'(bus.depth) > peak_depth) peak_depth = int'(bus.depth);
        end
    end

    // ---------------- stimulus helpers -----------------------------------
    task automatic send_tok(input logic [1:0] kind, input logic [7:0] value);
        int n;
        bus.tok_valid = 1'b1;
        bus.tok_kind  = kind;
        bus.tok_value = value;
        n = 0;
        @(negedge clk);
        while (!bus.tok_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tok_ready) check("tok_ready_timeout", 32'(bus.tok_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.tok_valid = 1'b0;
    endtask

    task automatic wait_result(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check({name, "_result_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string name, input logic [2:0] exp_ops[$]);
        check({name, "_op_count"}, 32'(op_log.size()), 32'(exp_ops.size()));
        for (int i = 0; i < exp_ops.size() && i < op_log.size(); i++)
            check({name, "_opcode"}, 32'(op_log[i]), 32'(exp_ops[i]));
    endtask

    task automatic start_expr();
        op_log.delete();
        peak_depth = 0;
    endtask

    // ---------------- directed stimulus ----------------------------------
    initial begin
        logic [2:0] ops[$];
        int n;
        bus.tok_valid = 1'b0;
        bus.tok_kind  = 2'b00;
        bus.tok_value = 8'h00;
        bus.res_ready = 1'b1;

        #12;
        check("rst_opcode", 32'(bus.alu_opcode), 32'd0);
        check("rst_alu_data", 32'(bus.alu_data), 32'd0);
        check("rst_depth", 32'(bus.depth), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_res_flags", 32'({bus.res_overflow, bus.res_error}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check("rst_tok_ready", 32'(bus.tok_ready), 32'd1);

        // 3 4 + end = 7
        start_expr();
        sb.push_back(exp_t'{8'd7, 1'b0, 1'b0});
        send_tok(2'b00, 8'd3); send_tok(2'b00, 8'd4); send_tok(2'b01, 8'd0); send_tok(2'b11, 8'd0);
        wait_result("add");
        ops = '{3'b110, 3'b110, 3'b100, 3'b111, 3'b111, 3'b110, 3'b111};
        check_log("add", ops);

        // 2 3 4 * + end = 14, peak depth 3
        start_expr();
        sb.push_back(exp_t'{8'd14, 1'b0, 1'b0});
        send_tok(2'b00, 8'd2); send_tok(2'b00, 8'd3); send_tok(2'b00, 8'd4);
        send_tok(2'b10, 8'd0); send_tok(2'b01, 8'd0); send_tok(2'b11, 8'd0);
        wait_result("muladd");
        check("muladd_peak_depth", 32'(peak_depth), 32'd3);

        // 100 100 + end = 0xC8 with overflow
        start_expr();
        sb.push_back(exp_t'{8'hC8, 1'b1, 1'b0});
        send_tok(2'b00, 8'd100); send_tok(2'b00, 8'd100); send_tok(2'b01, 8'd0); send_tok(2'b11, 8'd0);
        wait_result("ovf");

        // 5 + -> error, one drain pop
        start_expr();
        sb.push_back(exp_t'{8'd0, 1'b0, 1'b1});
        send_tok(2'b00, 8'd5); send_tok(2'b01, 8'd0);
        wait_result("underflow");
        ops = '{3'b110, 3'b111};
        check_log("underflow", ops);

        // 1 2 end -> error, two drain pops
        start_expr();
        sb.push_back(exp_t'{8'd0, 1'b0, 1'b1});
        send_tok(2'b00, 8'd1); send_tok(2'b00, 8'd2); send_tok(2'b11, 8'd0);
        wait_result("bad_end");
        ops = '{3'b110, 3'b110, 3'b111, 3'b111};
        check_log("bad_end", ops);

        // 16 operands -> 16th overflows the stack; hold result for 10 cycles
        start_expr();
        sb.push_back(exp_t'{8'd0, 1'b0, 1'b1});
        for (int i = 0; i < 15; i++) send_tok(2'b00, 8'(i + 1));
        bus.res_ready = 1'b0;
        send_tok(2'b00, 8'd16);
        n = 0;
        @(negedge clk);
        while (!bus.res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("full_res_valid_seen", 32'(bus.res_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_res_valid", 32'(bus.res_valid), 32'd1);
            check("hold_res_data", 32'(bus.res_data), 32'd0);
            check("hold_tok_ready", 32'(bus.tok_ready), 32'd0);
        end
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        wait_result("full");
        ops.delete();
        for (int i = 0; i < 15; i++) ops.push_back(3'b110);
        for (int i = 0; i < 15; i++) ops.push_back(3'b111);
        check_log("full", ops);

        // Reset asserted during POP2 of an add
        start_expr();
        send_tok(2'b00, 8'd1); send_tok(2'b00, 8'd2); send_tok(2'b01, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pop2_opcode", 32'(bus.alu_opcode), 32'd7);
        check("pop2_depth", 32'(bus.depth), 32'd2);
        reset = 1'b0;
        #1;
        check("async_rst_opcode", 32'(bus.alu_opcode), 32'd0);
        check("async_rst_alu_data", 32'(bus.alu_data), 32'd0);
        check("async_rst_depth", 32'(bus.depth), 32'd0);
        check("async_rst_res_valid", 32'(bus.res_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check("post_rst_tok_ready", 32'(bus.tok_ready), 32'd1);

        // 6 7 * end = 42
        start_expr();
        sb.push_back(exp_t'{8'd42, 1'b0, 1'b0});
        send_tok(2'b00, 8'd6); send_tok(2'b00, 8'd7); send_tok(2'b10, 8'd0); send_tok(2'b11, 8'd0);
        wait_result("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
